blake2_msg_packer: RTL and testbench
====================================

// Module: blake2_msg_packer
// PURPOSE
//  Upstream stage of the blake2 top: packs a word-serial message into 16-word (bb-byte) blocks,
//  zero-pads the final block and keeps the running byte counter t (F offset input).
//  Emits one block per valid/ready handshake with t and a final-block flag, so the
//  compression stage can run dd > 1 blocks. No key support (kk = 0).
// PARAMETERS
//  W      64        word width in bits (64 = BLAKE2b, 32 = BLAKE2s); bb = 2*W bytes per block
//  CNT_W  2*W       width of byte counter t (wraps mod 2**CNT_W)
//  NB_W   clog2(W/8)+1  width of byte-count field (localparam, derived from W)
// PORTS
//  clk         in   1        clock, rising edge
//  nreset      in   1        asynchronous active-low reset
//  in_valid_i  in   1        input word valid
//  in_ready_o  out  1        packer can accept a word
//  in_data_i   in   W        message word, little-endian (byte 0 in bits [7:0])
//  in_nbytes_i in   NB_W     valid bytes in word, 0..W/8; < W/8 only on last beat
//  in_last_i   in   1        last beat of message
//  blk_valid_o out  1        block available
//  blk_ready_i in   1        downstream accepts block
//  blk_data_o  out  16*W     block; word k at [k*W +: W]
//  blk_t_o     out  CNT_W    cumulative bytes up to and including this block
//  blk_last_o  out  1        final block of message (f0 = all ones downstream)
//  err_o       out  1        one-cycle pulse on input protocol violation
// BEHAVIOUR
//  - Reset (async, nreset=0): state FILL, word idx 0, t 0, block reg 0, blk_valid_o 0,
//    blk_last_o 0, blk_t_o 0, err_o 0, in_ready_o 1 after release. Partial block discarded.
//  - States: FILL (in_ready_o=1, blk_valid_o=0), FULL (in_ready_o=0, blk_valid_o=1).
//  - FILL accept (in_valid_i & in_ready_o): word written at idx with bytes >= nbytes zeroed;
//    t += nbytes; idx++. Goto FULL if idx was 15 or in_last_i. blk_last_o := in_last_i.
//  - blk_valid_o rises the cycle after the accepting edge (latency 1). Block fields, t and
//    last held stable while FULL regardless of inputs.
//  - FULL & blk_ready_i: block reg cleared to zero, idx 0, back to FILL next cycle. t kept
//    unless blk_last_o, then t cleared to 0 for next message. No same-cycle bypass.
//  - Exact multiple of bb: last arrives with 16th word -> single final block, no extra block.
//  - Empty message: first beat with nbytes 0 and last -> all-zero block, t=0, last=1.
//  - Errors (err_o pulse, beat still accepted):
//    nbytes < W/8 without last -> treated as W/8;  nbytes > W/8 -> clamped to W/8;
//    nbytes 0 & last with idx 0 but t != 0 -> emits all-zero final block with current t.
//  - t arithmetic: unsigned CNT_W, wraps silently.
// STRUCTURE
//  - Shared package blake2_pkg: IV constants, BB bytes localparam, rotation constants,
//    packer state enum {FILL, FULL}.
//  - Sub-module blake2_byte_mask: combinational nbytes -> W-bit byte-lane mask (with clamp).
//  - Block storage: 16 x W register array, write-indexed by idx (4-bit counter).
// TESTING (W=64 unless noted)
//  1. Empty msg: one beat nbytes=0,last=1 -> one block, data all 0, t=0, last=1, err 0.
//  2. "abc": data 0x...636261 nbytes=3 last -> word0=0x0000000000636261, rest 0, t=3,
//     last=1; through blake2 NN=32 -> bddd813c634239723171ef3fee98579b94964e3bb1cb3e427262c8c068d52319.
//  3. 128 bytes: 16 full beats, last on 16th -> exactly one block, t=128, last=1.
//  4. 129 bytes: block0 t=128 last=0; block1 word0=0x00..00XX (1 byte), t=129, last=1.
//  5. Backpressure: blk_ready_i low 5 cycles while FULL -> outputs stable, in_ready_o=0,
//     in_valid_i activity ignored; ready high -> FILL next cycle, next message t restarts 0.
//  6. nreset asserted after 7 beats -> outputs zero immediately; fresh "abc" yields case 2.

Source files
------------

// File: rtl/blake2_pkg.sv
// Shared BLAKE2 definitions: IVs, block geometry, G-function rotations and
// the message packer state encoding.
package blake2_pkg;

    localparam int unsigned BLK_WORDS  = 16;
    localparam int unsigned IDX_W      = 4;
    localparam int unsigned BB_BYTES_B = 128;
    localparam int unsigned BB_BYTES_S = 64;

    localparam logic [63:0] IV_B [8] = '{
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
        64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
        64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    localparam logic [31:0] IV_S [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam int unsigned ROT_B [4] = '{32, 24, 16, 63};
    localparam int unsigned ROT_S [4] = '{16, 12, 8, 7};

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } packer_state_e;

    // Width of a byte-count field able to hold 0..W/8 plus out-of-range values.
    function automatic int unsigned nb_width(input int unsigned w);
        return $clog2(w / 8) + 1;
    endfunction

endpackage

// File: rtl/blake2_msg_packer_if.sv
// Word-in / block-out handshake bundle of the BLAKE2 message packer.
// The packer uses the slave view; the producer/consumer side uses master.
interface blake2_msg_packer_if #(
    parameter int unsigned W     = 64,
    parameter int unsigned CNT_W = 2 * W
);
    import blake2_pkg::*;

    localparam int unsigned NB_W = nb_width(W);

    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [W-1:0]           in_data_i;
    logic [NB_W-1:0]        in_nbytes_i;
    logic                   in_last_i;
    logic                   blk_valid_o;
    logic                   blk_ready_i;
    logic [BLK_WORDS*W-1:0] blk_data_o;
    logic [CNT_W-1:0]       blk_t_o;
    logic                   blk_last_o;
    logic                   err_o;

    modport slave (
        input  in_valid_i, in_data_i, in_nbytes_i, in_last_i, blk_ready_i,
        output in_ready_o, blk_valid_o, blk_data_o, blk_t_o, blk_last_o, err_o
    );

    modport master (
        output in_valid_i, in_data_i, in_nbytes_i, in_last_i, blk_ready_i,
        input  in_ready_o, blk_valid_o, blk_data_o, blk_t_o, blk_last_o, err_o
    );

endinterface

// File: rtl/blake2_byte_mask.sv
// Turns a beat byte count into a byte-lane mask, clamping oversize counts and
// promoting short counts to a full word on beats that are not the last.
module blake2_byte_mask #(
    parameter int unsigned W    = 64,
    parameter int unsigned NB_W = $clog2(W / 8) + 1
) (
    input  logic [NB_W-1:0] i_nbytes,
    input  logic            i_force_full,
    output logic [W-1:0]    o_mask,
    output logic [NB_W-1:0] o_nbytes,
    output logic            o_clamped,
    output logic            o_short
);

    localparam int unsigned     BPW    = W / 8;
    localparam logic [NB_W-1:0] BPW_NB = NB_W'(BPW);

    // Effective byte count and the two protocol-violation flavours.
    always_comb begin
        o_clamped = 1'b0;
        o_short   = 1'b0;
        o_nbytes  = i_nbytes;
        if (i_nbytes > BPW_NB) begin
            o_clamped = 1'b1;
            o_nbytes  = BPW_NB;
        end else if ((i_nbytes < BPW_NB) && i_force_full) begin
            o_short  = 1'b1;
            o_nbytes = BPW_NB;
        end else begin
            o_nbytes = i_nbytes;
        end
    end

    // Lane b kept when b < effective count (little-endian byte order).
    always_comb begin
        o_mask = {W{1'b0}};
        for (int b = 0; b < BPW; b++) begin
            if (NB_W'(b) < o_nbytes) begin
                o_mask[8*b +: 8] = 8'hFF;
            end else begin
                o_mask[8*b +: 8] = 8'h00;
            end
        end
    end

endmodule

// File: rtl/blake2_msg_packer.sv
// Packs a word-serial message into zero-padded 16-word BLAKE2 blocks and tracks
// the running byte offset t; one block per handshake, tagged with a final flag.
module blake2_msg_packer
    import blake2_pkg::*;
#(
    parameter int unsigned W     = 64,
    parameter int unsigned CNT_W = 2 * W
) (
    input  logic               clk,
    input  logic               nreset,
    blake2_msg_packer_if.slave bus
);

    localparam int unsigned NB_W = nb_width(W);

    packer_state_e    r_state;
    packer_state_e    w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [W-1:0]     r_blk [BLK_WORDS];
    logic [CNT_W-1:0] r_t;
    logic             r_last;
    logic             r_err;

    logic             w_accept;
    logic             w_release;
    logic             w_to_full;
    logic             w_empty_err;
    logic             w_err;
    logic [W-1:0]     w_mask;
    logic [NB_W-1:0]  w_nb_eff;
    logic             w_clamped;
    logic             w_short;

    blake2_byte_mask #(
        .W    (W),
        .NB_W (NB_W)
    ) u_mask (
        .i_nbytes     (bus.in_nbytes_i),
        .i_force_full (~bus.in_last_i),
        .o_mask       (w_mask),
        .o_nbytes     (w_nb_eff),
        .o_clamped    (w_clamped),
        .o_short      (w_short)
    );

    assign w_accept    = bus.in_valid_i & (r_state == ST_FILL);
    assign w_release   = (r_state == ST_FULL) & bus.blk_ready_i;
    assign w_to_full   = (r_idx == IDX_W'(BLK_WORDS - 1)) | bus.in_last_i;
    // An empty closing beat is only legal for a genuinely empty message.
    assign w_empty_err = bus.in_last_i & (bus.in_nbytes_i == NB_W'(0)) &
                         (r_idx == IDX_W'(0)) & (r_t != CNT_W'(0));
    assign w_err       = w_accept & (w_clamped | w_short | w_empty_err);

    // State register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: fill until the block is complete, then hold until taken.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FILL: begin
                if (w_accept && w_to_full) begin
                    w_state_nxt = ST_FULL;
                end else begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_FULL: begin
                if (bus.blk_ready_i) begin
                    w_state_nxt = ST_FILL;
                end else begin
                    w_state_nxt = ST_FULL;
                end
            end
            default: w_state_nxt = ST_FILL;
        endcase
    end

    // Block storage, byte counter, final flag and error pulse.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_idx  <= IDX_W'(0);
            r_t    <= CNT_W'(0);
            r_last <= 1'b0;
            r_err  <= 1'b0;
            for (int k = 0; k < BLK_WORDS; k++) begin
                r_blk[k] <= {W{1'b0}};
            end
        end else begin
            r_err <= w_err;
            if (w_accept) begin
                r_blk[r_idx] <= bus.in_data_i & w_mask;
                r_t          <= r_t + CNT_W'(w_nb_eff);
                r_idx        <= r_idx + IDX_W'(1);
                r_last       <= bus.in_last_i;
            end else if (w_release) begin
                for (int k = 0; k < BLK_WORDS; k++) begin
                    r_blk[k] <= {W{1'b0}};
                end
                r_idx  <= IDX_W'(0);
                r_last <= 1'b0;
                // The next message restarts its offset from zero.
                if (r_last) begin
                    r_t <= CNT_W'(0);
                end else begin
                    r_t <= r_t;
                end
            end else begin
                r_idx <= r_idx;
            end
        end
    end

    // Flatten the word array onto the block bus (word k at [k*W +: W]).
    always_comb begin
        bus.blk_data_o = {(BLK_WORDS*W){1'b0}};
        for (int k = 0; k < BLK_WORDS; k++) begin
            bus.blk_data_o[k*W +: W] = r_blk[k];
        end
    end

    assign bus.in_ready_o  = (r_state == ST_FILL);
    assign bus.blk_valid_o = (r_state == ST_FULL);
    assign bus.blk_t_o     = r_t;
    assign bus.blk_last_o  = r_last;
    assign bus.err_o       = r_err;

endmodule

// File: tb/tb_blake2_msg_packer.sv
// Directed plus randomized bench for blake2_msg_packer (W=64) against a
// beat/byte-level block model.
module tb_blake2_msg_packer;

    localparam int unsigned W = 64;

    logic clk = 1'b0;
    logic nreset;
    int   checks = 0;
    int   errors = 0;

    blake2_msg_packer_if #(.W(W)) bus ();

    blake2_msg_packer #(.W(W)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Pending input beats and expected outputs.
    logic [63:0]   b_data [$];
    int            b_nb   [$];
    bit            b_last [$];
    bit            e_err  [$];
    logic [1023:0] e_data [$];
    logic [127:0]  e_t    [$];
    bit            e_last [$];

    // Model state of the message being built.
    logic [1023:0] m_blk;
    logic [127:0]  m_t;
    int            m_pos;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_blk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        int k;
        checks++;
        assert (got === exp) else begin
            errors++;
            k = 0;
            while (k < 15 && got[k*64 +: 64] === exp[k*64 +: 64]) k++;
            $error("FAIL %s word%0d got=%h exp=%h", tag, k, got[k*64 +: 64], exp[k*64 +: 64]);
        end
    endtask

    task automatic model_reset();
        m_blk = '0;
        m_t   = '0;
        m_pos = 0;
        b_data.delete(); b_nb.delete(); b_last.delete(); e_err.delete();
        e_data.delete(); e_t.delete(); e_last.delete();
    endtask

    // Queue one beat and extend the expected block stream.
    task automatic add_beat(input logic [63:0] data, input int nb, input bit last);
        int eff;
        bit err;
        eff = (nb > 8) ? 8 : nb;
        err = (nb > 8);
        if (!last && eff < 8) begin
            eff = 8;
            err = 1'b1;
        end
        if (last && nb == 0 && m_pos == 0 && m_t != 0) err = 1'b1;
        for (int i = 0; i < eff; i++) m_blk[m_pos*64 + 8*i +: 8] = data[8*i +: 8];
        m_t   = m_t + 128'(eff);
        m_pos = m_pos + 1;
        if (m_pos == 16 || last) begin
            e_data.push_back(m_blk);
            e_t.push_back(m_t);
            e_last.push_back(last);
            m_blk = '0;
            m_pos = 0;
            if (last) m_t = '0;
        end
        b_data.push_back(data);
        b_nb.push_back(nb);
        b_last.push_back(last);
        e_err.push_back(err);
    endtask

    task automatic add_msg(input int len);
        int nbeats;
        int rem;
        nbeats = (len == 0) ? 1 : (len + 7) / 8;
        for (int j = 0; j < nbeats; j++) begin
            rem = len - 8 * j;
            add_beat({$urandom, $urandom}, (rem > 8) ? 8 : rem, j == nbeats - 1);
        end
    endtask

    // Drive queued beats with random valid/ready gaps and score every block.
    task automatic run(input int rdy_pct, input int vld_pct, input int budget);
        int cyc;
        bit exp_err;
        cyc     = 0;
        exp_err = 1'b0;
        while ((b_data.size() > 0 || e_data.size() > 0) && cyc < budget) begin
            bus.in_valid_i = (b_data.size() > 0) && ($urandom_range(99) < vld_pct);
            if (b_data.size() > 0) begin
                bus.in_data_i   = b_data[0];
                bus.in_nbytes_i = 4'(b_nb[0]);
                bus.in_last_i   = b_last[0];
            end else begin
                bus.in_data_i   = {$urandom, $urandom};
                bus.in_nbytes_i = 4'($urandom_range(15));
                bus.in_last_i   = 1'($urandom_range(1));
            end
            bus.blk_ready_i = ($urandom_range(99) < rdy_pct);
            @(negedge clk);
            chk("err", bus.err_o, exp_err);
            if (bus.blk_valid_o && bus.blk_ready_i) begin
                checks++;
                assert (e_data.size() > 0) else begin
                    errors++;
                    $error("FAIL extra_block got=1 exp=0");
                end
                if (e_data.size() > 0) begin
                    chk_blk("blk_data", bus.blk_data_o, e_data[0]);
                    chk("blk_t", bus.blk_t_o, e_t[0]);
                    chk("blk_last", bus.blk_last_o, e_last[0]);
                    void'(e_data.pop_front());
                    void'(e_t.pop_front());
                    void'(e_last.pop_front());
                end
            end
            exp_err = 1'b0;
            if (bus.in_valid_i && bus.in_ready_o) begin
                exp_err = e_err.pop_front();
                void'(b_data.pop_front());
                void'(b_nb.pop_front());
                void'(b_last.pop_front());
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.in_valid_i  = 1'b0;
        bus.blk_ready_i = 1'b0;
        checks++;
        assert (b_data.size() == 0 && e_data.size() == 0) else begin
            errors++;
            $error("FAIL timeout beats_left=%0d blocks_left=%0d exp=0", b_data.size(), e_data.size());
        end
    endtask

    initial begin
        bit exp_err;
        nreset          = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = 64'h0;
        bus.in_nbytes_i = 4'h0;
        bus.in_last_i   = 1'b0;
        bus.blk_ready_i = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 nreset = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready_o, 128'd1);
        chk("rst_blk_valid", bus.blk_valid_o, 128'd0);
        chk("rst_blk_t", bus.blk_t_o, 128'd0);
        chk("rst_blk_last", bus.blk_last_o, 128'd0);
        chk("rst_err", bus.err_o, 128'd0);
        chk_blk("rst_blk_data", bus.blk_data_o, '0);
        @(posedge clk);
        #1;

        // Empty message, "abc", exact 128 bytes, 129 bytes
        add_msg(0);
        run(100, 100, 200);
        add_beat(64'hFFFFFFFFFF636261, 3, 1'b1);
        run(100, 100, 200);
        add_msg(128);
        run(100, 100, 400);
        add_msg(129);
        run(60, 70, 800);

        // Backpressure: block held while downstream stalls, input ignored
        add_beat(64'hA5A5A5A5A5636261, 3, 1'b1);
        bus.in_valid_i  = 1'b1;
        bus.in_data_i   = b_data[0];
        bus.in_nbytes_i = 4'(b_nb[0]);
        bus.in_last_i   = 1'b1;
        @(negedge clk);
        chk("bp_accept_ready", bus.in_ready_o, 128'd1);
        @(posedge clk);
        #1;
        exp_err = e_err.pop_front();
        void'(b_data.pop_front());
        void'(b_nb.pop_front());
        void'(b_last.pop_front());
        for (int c = 0; c < 5; c++) begin
            bus.in_valid_i  = 1'b1;
            bus.in_data_i   = {$urandom, $urandom};
            bus.in_nbytes_i = 4'($urandom_range(15));
            bus.in_last_i   = 1'($urandom_range(1));
            bus.blk_ready_i = 1'b0;
            @(negedge clk);
            if (c == 0) chk("bp_err", bus.err_o, 128'(exp_err));
            chk("bp_valid", bus.blk_valid_o, 128'd1);
            chk("bp_in_ready", bus.in_ready_o, 128'd0);
            chk_blk("bp_data", bus.blk_data_o, e_data[0]);
            chk("bp_t", bus.blk_t_o, e_t[0]);
            chk("bp_last", bus.blk_last_o, 128'(e_last[0]));
            @(posedge clk);
            #1;
        end
        bus.in_valid_i  = 1'b0;
        bus.blk_ready_i = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", bus.blk_valid_o, 128'd1);
        void'(e_data.pop_front());
        void'(e_t.pop_front());
        void'(e_last.pop_front());
        @(posedge clk);
        #1;
        bus.blk_ready_i = 1'b0;
        @(negedge clk);
        chk("bp_refill_ready", bus.in_ready_o, 128'd1);
        chk("bp_refill_valid", bus.blk_valid_o, 128'd0);
        chk("bp_refill_t", bus.blk_t_o, 128'd0);
        @(posedge clk);
        #1;
        add_beat(64'h0000000000636261, 3, 1'b1);
        run(100, 100, 200);

        // Protocol violations: oversize, short non-last, empty close after full block
        add_beat({$urandom, $urandom}, 9, 1'b1);
        run(80, 80, 200);
        add_beat({$urandom, $urandom}, 3, 1'b0);
        add_beat({$urandom, $urandom}, 2, 1'b1);
        run(80, 80, 200);
        for (int j = 0; j < 16; j++) add_beat({$urandom, $urandom}, 8, 1'b0);
        add_beat({$urandom, $urandom}, 0, 1'b1);
        run(80, 80, 600);
        add_beat({$urandom, $urandom}, 0, 1'b0);
        add_beat({$urandom, $urandom}, 15, 1'b0);
        add_beat({$urandom, $urandom}, 5, 1'b1);
        run(80, 80, 200);

        // Random message lengths with random stalls on both sides
        for (int m = 0; m < 20; m++) add_msg(int'($urandom_range(300)));
        run(70, 80, 20000);

        // Reset in the middle of a message discards the partial block
        for (int j = 0; j < 7; j++) begin
            bus.in_valid_i  = 1'b1;
            bus.in_data_i   = {$urandom, $urandom};
            bus.in_nbytes_i = 4'd8;
            bus.in_last_i   = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        chk("pre_reset_t", bus.blk_t_o, 128'd56);
        #2 nreset = 1'b0;
        #1;
        chk("mid_rst_t", bus.blk_t_o, 128'd0);
        chk("mid_rst_valid", bus.blk_valid_o, 128'd0);
        chk("mid_rst_last", bus.blk_last_o, 128'd0);
        chk("mid_rst_err", bus.err_o, 128'd0);
        chk_blk("mid_rst_data", bus.blk_data_o, '0);
        @(posedge clk);
        #1 nreset = 1'b1;
        model_reset();
        add_beat(64'h0000000000636261, 3, 1'b1);
        run(100, 100, 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
